// File: rtl/wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// wb_pipe_reg
// Pipeline register between the memory-access and write-back stages. Carries
// NUM_CH independent write channels (address, enable, data) plus a valid bit.
//
// Per-edge action, in priority order:
//   reset  : clear everything (and the counters)
//   flush  : clear the stage, counters untouched, stall ignored
//   hold   : stall[STAGE+1]=1, keep contents
//   bubble : stall[STAGE]=1 and stall[STAGE+1]=0, clear the stage
//   load   : capture inputs; write enables are gated by valid_i
//
// Optional feature macro: WB_PIPE_PERF_CNT_EN
//   When defined, adds saturating bubble/hold counters and a synchronous clear.
//
// Ports:
//   clk          in   clock, all state changes on posedge
//   rst          in   synchronous active-high reset
//   stall        in   STALL_W stall vector, 1 = stop
//   flush_i      in   exception flush
//   valid_i      in   producer slot holds a real instruction
//   ch_waddr_i   in   packed addresses, channel k at [k*ADDR_W +: ADDR_W]
//   ch_we_i      in   per-channel write enables
//   ch_wdata_i   in   packed data, channel k at [k*DATA_W +: DATA_W]
//   valid_o      out  registered valid
//   ch_waddr_o   out  registered addresses
//   ch_we_o      out  registered, valid-gated write enables
//   ch_wdata_o   out  registered data
//   cnt_clr_i    in   counter clear            (macro only)
//   bubble_cnt_o out  bubbles inserted         (macro only)
//   hold_cnt_o   out  hold cycles              (macro only)
// -----------------------------------------------------------------------------
module wb_pipe_reg #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_waddr_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic                     valid_o,
  output logic [NUM_CH*ADDR_W-1:0] ch_waddr_o,
  output logic [NUM_CH-1:0]        ch_we_o,
  output logic [NUM_CH*DATA_W-1:0] ch_wdata_o
`ifdef WB_PIPE_PERF_CNT_EN
  ,
  input  logic                     cnt_clr_i,
  output logic [CNT_W-1:0]         bubble_cnt_o,
  output logic [CNT_W-1:0]         hold_cnt_o
`endif
);

  logic w_hold;
  logic w_bubble;
  logic w_clear;
  logic w_unused_stall;

  // Consumer stalled: keep contents no matter what the producer does.
  assign w_hold   = stall[STAGE+1];
  // Producer stalled but consumer free: push a bubble downstream.
  assign w_bubble = stall[STAGE] & ~stall[STAGE+1];
  // Reset and flush outrank the stall bits, so they sit in front of the hold.
  assign w_clear  = rst | flush_i | w_bubble;

  // Only two bits of the stall vector belong to this stage.
  assign w_unused_stall = ^stall;

  logic r_valid;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_valid <= valid_i;
    end
  end

  assign valid_o = r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ADDR_W-1:0] r_waddr;
      logic              r_we;
      logic [DATA_W-1:0] r_wdata;

      always_ff @(posedge clk) begin
        if (w_clear) begin
          r_waddr <= '0;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end else if (!w_hold) begin
          // Address/data load regardless of valid; only the enable is gated,
          // so an invalid slot can never cause a register write.
          r_waddr <= ch_waddr_i[gi*ADDR_W +: ADDR_W];
          r_we    <= ch_we_i[gi] & valid_i;
          r_wdata <= ch_wdata_i[gi*DATA_W +: DATA_W];
        end
      end

      assign ch_waddr_o[gi*ADDR_W +: ADDR_W] = r_waddr;
      assign ch_we_o[gi]                     = r_we;
      assign ch_wdata_o[gi*DATA_W +: DATA_W] = r_wdata;
    end
  endgenerate

`ifdef WB_PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Clear wins over increment; flush freezes both counters; saturate at '1.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      r_hold_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else if (!flush_i) begin
      if (w_hold && (r_hold_cnt != '1)) begin
        r_hold_cnt <= r_hold_cnt + LP_CNT_ONE;
      end
      if (w_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + LP_CNT_ONE;
      end
    end
  end

  assign hold_cnt_o   = r_hold_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule
